// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide RAM port arbiter/sequencer.
package mem_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam logic [31:0] DEF_IO_BASE = 32'h0003_0000;

    // Bus types
    typedef logic [DEF_ADDR_W-1:0] addr_bus_t;
    typedef logic [31:0]           inst_bus_t;
    typedef logic [31:0]           data_bus_t;
    typedef logic [7:0]            byte_bus_t;

    // Load/store size encodings (3 is illegal and handled as a word)
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_t;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IF_RD = 2'd1,
        ST_LS_RD = 2'd2,
        ST_LS_WR = 2'd3
    } state_t;

    // Index of the last byte of a transfer of the given size
    function automatic logic [1:0] size_last(input logic [1:0] size);
        case (size)
            SIZE_B:  return 2'd0;
            SIZE_H:  return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Fetch, load/store and RAM port signals of the memory controller.
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    // Instruction fetch
    logic              IF_req;
    logic [ADDR_W-1:0] IF_addr;
    logic              IF_done;
    logic [31:0]       IF_inst;
    // Load/store buffer
    logic              LS_req;
    logic              LS_we;
    logic [1:0]        LS_size;
    logic [ADDR_W-1:0] LS_addr;
    logic [31:0]       LS_wdata;
    logic              LS_done;
    logic [31:0]       LS_rdata;
    // RAM port and I/O status
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    // Controller side
    modport slave (
        input  IF_req, IF_addr, LS_req, LS_we, LS_size, LS_addr, LS_wdata,
        input  mem_din, io_buffer_full,
        output IF_done, IF_inst, LS_done, LS_rdata,
        output mem_dout, mem_a, mem_wr
    );

    // Requester / RAM side
    modport master (
        output IF_req, IF_addr, LS_req, LS_we, LS_size, LS_addr, LS_wdata,
        output mem_din, io_buffer_full,
        input  IF_done, IF_inst, LS_done, LS_rdata,
        input  mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl.sv
// Arbiter/sequencer for the single byte-wide RAM port shared by instruction
// fetch and the load/store buffer. Splits requests into byte transfers and
// assembles little-endian read data.
// Optional feature macro: MEMCTRL_IOBUF_EN (stall I/O writes on full UART buffer).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W  = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(DEF_IO_BASE)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    mem_ctrl_if.slave   bus
);

    state_t            state;
    logic [1:0]        cnt;
    logic [1:0]        last;
    logic              tail;
    logic [31:0]       sh;
    logic [ADDR_W-1:0] a_r;
    logic [7:0]        dout_r;
    logic              wr_r;
    logic              if_done_r;
    logic              ls_done_r;
    logic [31:0]       if_inst_r;
    logic [31:0]       ls_rdata_r;

    logic [ADDR_W-1:0] a_next;
    logic [31:0]       rd_shift;
    logic [31:0]       rd_word;
    logic              ls_is_io;
    logic              a_is_io;
    logic              a_next_is_io;
    logic              stall_first;
    logic              stall_next;
    logic              stall_hold;

    assign a_next       = a_r + ADDR_W'(1);
    assign ls_is_io     = (bus.LS_addr >= IO_BASE);
    assign a_is_io      = (a_r >= IO_BASE);
    assign a_next_is_io = (a_next >= IO_BASE);

    // Every read cycle shifts mem_din in from the top; the first shift carries
    // a stale byte that is always pushed out by the right-alignment below.
    assign rd_shift = {bus.mem_din, sh[31:8]};

    // Right-align the assembled bytes according to the transfer length
    always_comb begin
        rd_word = rd_shift;
        case (last)
            2'd0:    rd_word = {24'h0, rd_shift[31:24]};
            2'd1:    rd_word = {16'h0, rd_shift[31:16]};
            default: rd_word = rd_shift;
        endcase
    end

    // Write stall decisions: hold off I/O bytes while the UART buffer is full
    // and leave one idle cycle after every I/O byte.
`ifdef MEMCTRL_IOBUF_EN
    always_comb begin
        stall_first = ls_is_io && bus.io_buffer_full;
        stall_next  = a_is_io || (a_next_is_io && bus.io_buffer_full);
        stall_hold  = a_is_io && bus.io_buffer_full;
    end
`else
    logic unused_io;
    assign unused_io = ^{bus.io_buffer_full, ls_is_io, a_is_io, a_next_is_io};
    always_comb begin
        stall_first = 1'b0;
        stall_next  = 1'b0;
        stall_hold  = 1'b0;
    end
`endif

    // Sequencer FSM with registered RAM and completion outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last       <= '0;
            tail       <= 1'b0;
            sh         <= '0;
            a_r        <= '0;
            dout_r     <= '0;
            wr_r       <= 1'b0;
            if_done_r  <= 1'b0;
            ls_done_r  <= 1'b0;
            if_inst_r  <= '0;
            ls_rdata_r <= '0;
        end else if (rdy) begin
            if_done_r <= 1'b0;
            ls_done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!clr) begin
                        if (bus.LS_req) begin
                            a_r  <= bus.LS_addr;
                            cnt  <= '0;
                            tail <= 1'b0;
                            last <= size_last(bus.LS_size);
                            if (bus.LS_we) begin
                                state  <= ST_LS_WR;
                                dout_r <= bus.LS_wdata[7:0];
                                sh     <= {8'h00, bus.LS_wdata[31:8]};
                                wr_r   <= !stall_first;
                            end else begin
                                state <= ST_LS_RD;
                                wr_r  <= 1'b0;
                            end
                        end else if (bus.IF_req) begin
                            state <= ST_IF_RD;
                            a_r   <= bus.IF_addr;
                            cnt   <= '0;
                            tail  <= 1'b0;
                            last  <= 2'd3;
                            wr_r  <= 1'b0;
                        end
                    end
                end
                ST_IF_RD, ST_LS_RD: begin
                    if (clr) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        tail  <= 1'b0;
                    end else begin
                        sh <= rd_shift;
                        if (tail) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                            tail  <= 1'b0;
                            if (state == ST_IF_RD) begin
                                if_done_r <= 1'b1;
                                if_inst_r <= rd_word;
                            end else begin
                                ls_done_r  <= 1'b1;
                                ls_rdata_r <= rd_word;
                            end
                        end else if (cnt == last) begin
                            tail <= 1'b1;
                        end else begin
                            cnt <= cnt + 2'd1;
                            a_r <= a_next;
                        end
                    end
                end
                ST_LS_WR: begin
                    // A committed store ignores clr.
                    if (!wr_r) begin
                        wr_r <= !stall_hold;
                    end else if (cnt == last) begin
                        wr_r      <= 1'b0;
                        ls_done_r <= 1'b1;
                        state     <= ST_IDLE;
                        cnt       <= '0;
                    end else begin
                        cnt    <= cnt + 2'd1;
                        a_r    <= a_next;
                        dout_r <= sh[7:0];
                        sh     <= {8'h00, sh[31:8]};
                        wr_r   <= !stall_next;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_a    = a_r;
    assign bus.mem_dout = dout_r;
    assign bus.mem_wr   = wr_r && rdy;
    assign bus.IF_done  = if_done_r;
    assign bus.IF_inst  = if_inst_r;
    assign bus.LS_done  = ls_done_r;
    assign bus.LS_rdata = ls_rdata_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a one-cycle-latency RAM model.
module tb_mem_ctrl;

    logic clk;
    logic rst;
    logic rdy;
    logic clr;
    int   checks;
    int   errors;
    logic [7:0] ram [0:1023];
    logic       seen;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32), .IO_BASE(32'h0003_0000)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: read data appears the cycle after the address, writes on mem_wr
    always @(posedge clk) begin
        bus.mem_din <= ram[bus.mem_a[9:0]];
        if (bus.mem_wr) ram[bus.mem_a[9:0]] = bus.mem_dout;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h13; ram[10'h101] = 8'h00; ram[10'h102] = 8'h00; ram[10'h103] = 8'h00;
        ram[10'h104] = 8'h93; ram[10'h105] = 8'h80; ram[10'h106] = 8'h00; ram[10'h107] = 8'h01;
        ram[10'h200] = 8'h11; ram[10'h201] = 8'h22; ram[10'h202] = 8'h33; ram[10'h203] = 8'h44;
        ram[10'h010] = 8'h80; ram[10'h011] = 8'hFF;
        ram[10'h3FE] = 8'hAA; ram[10'h3FF] = 8'hBB; ram[10'h000] = 8'hCC; ram[10'h001] = 8'hDD;

        rst = 1'b1; rdy = 1'b1; clr = 1'b0;
        bus.IF_req = 1'b0; bus.IF_addr = '0;
        bus.LS_req = 1'b0; bus.LS_we = 1'b0; bus.LS_size = 2'd0;
        bus.LS_addr = '0; bus.LS_wdata = '0; bus.io_buffer_full = 1'b0;
        step(); step();

        // Reset state
        chk("rst_if_done", 32'(bus.IF_done), 32'h0);
        chk("rst_ls_done", 32'(bus.LS_done), 32'h0);
        chk("rst_mem_wr",  32'(bus.mem_wr), 32'h0);
        chk("rst_mem_a",   bus.mem_a, 32'h0);
        chk("rst_if_inst", bus.IF_inst, 32'h0);
        rst = 1'b0;
        step();

        // Instruction fetch of 0x100
        bus.IF_req = 1'b1; bus.IF_addr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("if_mem_a", bus.mem_a, 32'h100 + 32'(k));
            chk("if_mem_wr", 32'(bus.mem_wr), 32'h0);
            chk("if_done_early", 32'(bus.IF_done), 32'h0);
        end
        step();
        chk("if_done_c4", 32'(bus.IF_done), 32'h0);
        step();
        chk("if_done_c5", 32'(bus.IF_done), 32'h1);
        chk("if_inst", bus.IF_inst, 32'h0000_0013);
        bus.IF_req = 1'b0;
        step();
        chk("if_done_pulse", 32'(bus.IF_done), 32'h0);
        chk("if_inst_hold", bus.IF_inst, 32'h0000_0013);
        chk("idle_a_hold", bus.mem_a, 32'h103);

        // Simultaneous IF and LS: load word 0x200 goes first
        bus.IF_req = 1'b1; bus.IF_addr = 32'h104;
        bus.LS_req = 1'b1; bus.LS_we = 1'b0; bus.LS_size = 2'd2; bus.LS_addr = 32'h200;
        step();
        chk("prio_mem_a", bus.mem_a, 32'h200);
        for (int k = 1; k < 5; k++) step();
        chk("prio_ls_done_c4", 32'(bus.LS_done), 32'h0);
        step();
        chk("prio_ls_done", 32'(bus.LS_done), 32'h1);
        chk("prio_ls_rdata", bus.LS_rdata, 32'h4433_2211);
        chk("prio_if_done", 32'(bus.IF_done), 32'h0);
        bus.LS_req = 1'b0;
        step();
        chk("prio_if_start", bus.mem_a, 32'h104);
        for (int k = 1; k < 5; k++) step();
        chk("prio_if_done_c4", 32'(bus.IF_done), 32'h0);
        step();
        chk("prio_if_done2", 32'(bus.IF_done), 32'h1);
        chk("prio_if_inst", bus.IF_inst, 32'h0100_8093);
        bus.IF_req = 1'b0;
        step();

        // Store half 0xBEEF to 0x300
        bus.LS_req = 1'b1; bus.LS_we = 1'b1; bus.LS_size = 2'd1;
        bus.LS_addr = 32'h300; bus.LS_wdata = 32'hDEAD_BEEF;
        step();
        chk("sh_a0", bus.mem_a, 32'h300);
        chk("sh_d0", 32'(bus.mem_dout), 32'hEF);
        chk("sh_wr0", 32'(bus.mem_wr), 32'h1);
        step();
        chk("sh_a1", bus.mem_a, 32'h301);
        chk("sh_d1", 32'(bus.mem_dout), 32'hBE);
        chk("sh_wr1", 32'(bus.mem_wr), 32'h1);
        chk("sh_done_c1", 32'(bus.LS_done), 32'h0);
        step();
        chk("sh_done", 32'(bus.LS_done), 32'h1);
        chk("sh_wr_end", 32'(bus.mem_wr), 32'h0);
        bus.LS_req = 1'b0;
        step();
        chk("sh_ram", {16'h0, ram[10'h301], ram[10'h300]}, 32'h0000_BEEF);
        chk("sh_ram_untouched", 32'(ram[10'h302]), 32'h0);

        // Load byte 0x80 from 0x10, zero-extended
        bus.LS_req = 1'b1; bus.LS_we = 1'b0; bus.LS_size = 2'd0; bus.LS_addr = 32'h10;
        step();
        chk("lb_a", bus.mem_a, 32'h10);
        step();
        chk("lb_done_c1", 32'(bus.LS_done), 32'h0);
        step();
        chk("lb_done", 32'(bus.LS_done), 32'h1);
        chk("lb_rdata", bus.LS_rdata, 32'h0000_0080);
        bus.LS_req = 1'b0;
        step();

        // Illegal size 3 treated as word
        bus.LS_req = 1'b1; bus.LS_we = 1'b0; bus.LS_size = 2'd3; bus.LS_addr = 32'h200;
        for (int k = 0; k < 6; k++) step();
        chk("sz3_done", 32'(bus.LS_done), 32'h1);
        chk("sz3_rdata", bus.LS_rdata, 32'h4433_2211);
        bus.LS_req = 1'b0;
        step();

        // clr in cycle 2 of a fetch aborts it
        bus.IF_req = 1'b1; bus.IF_addr = 32'h100;
        step(); step(); step();
        chk("clr_if_a2", bus.mem_a, 32'h102);
        clr = 1'b1; bus.IF_req = 1'b0;
        step();
        clr = 1'b0;
        chk("clr_if_a_hold", bus.mem_a, 32'h102);
        seen = bus.IF_done;
        for (int k = 0; k < 5; k++) begin
            step();
            seen = seen | bus.IF_done;
        end
        chk("clr_if_no_done", 32'(seen), 32'h0);
        chk("clr_if_inst_hold", bus.IF_inst, 32'h0100_8093);

        // clr during a store: store still completes
        bus.LS_req = 1'b1; bus.LS_we = 1'b1; bus.LS_size = 2'd2;
        bus.LS_addr = 32'h304; bus.LS_wdata = 32'hA1B2_C3D4;
        step();
        chk("clrst_d0", 32'(bus.mem_dout), 32'hD4);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clrst_a2", bus.mem_a, 32'h306);
        chk("clrst_wr2", 32'(bus.mem_wr), 32'h1);
        step();
        chk("clrst_d3", 32'(bus.mem_dout), 32'hA1);
        step();
        chk("clrst_done", 32'(bus.LS_done), 32'h1);
        bus.LS_req = 1'b0;
        step();
        chk("clrst_ram", {ram[10'h307], ram[10'h306], ram[10'h305], ram[10'h304]}, 32'hA1B2_C3D4);

        // rdy low freezes the store and masks mem_wr
        bus.LS_req = 1'b1; bus.LS_we = 1'b1; bus.LS_size = 2'd0;
        bus.LS_addr = 32'h308; bus.LS_wdata = 32'h0000_005A;
        step();
        chk("rdy_wr_on", 32'(bus.mem_wr), 32'h1);
        rdy = 1'b0;
        #1;
        chk("rdy_wr_masked", 32'(bus.mem_wr), 32'h0);
        step();
        chk("rdy_frozen_done", 32'(bus.LS_done), 32'h0);
        chk("rdy_frozen_a", bus.mem_a, 32'h308);
        chk("rdy_no_write", 32'(ram[10'h308]), 32'h0);
        rdy = 1'b1;
        #1;
        chk("rdy_wr_resume", 32'(bus.mem_wr), 32'h1);
        step();
        chk("rdy_done", 32'(bus.LS_done), 32'h1);
        bus.LS_req = 1'b0;
        step();
        chk("rdy_ram", 32'(ram[10'h308]), 32'h5A);

        // Fetch address wraps modulo 2^32
        bus.IF_req = 1'b1; bus.IF_addr = 32'hFFFF_FFFE;
        step(); step(); step();
        chk("wrap_a2", bus.mem_a, 32'h0);
        step();
        chk("wrap_a3", bus.mem_a, 32'h1);
        step(); step();
        chk("wrap_done", 32'(bus.IF_done), 32'h1);
        chk("wrap_inst", bus.IF_inst, 32'hDDCC_BBAA);
        bus.IF_req = 1'b0;
        step();

`ifdef MEMCTRL_IOBUF_EN
        // I/O store stalls while the UART buffer is full
        bus.LS_req = 1'b1; bus.LS_we = 1'b1; bus.LS_size = 2'd0;
        bus.LS_addr = 32'h0003_0000; bus.LS_wdata = 32'h0000_0041;
        bus.io_buffer_full = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            seen = seen | bus.mem_wr;
        end
        chk("io_stall_wr", 32'(seen), 32'h0);
        bus.io_buffer_full = 1'b0;
        step();
        chk("io_wr", 32'(bus.mem_wr), 32'h1);
        chk("io_a", bus.mem_a, 32'h0003_0000);
        step();
        chk("io_done", 32'(bus.LS_done), 32'h1);
        bus.LS_req = 1'b0;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
